// File: rtl/branch_determination_unit_pkg.sv
// branch_determination_unit_pkg: RV32I branch funct3 encodings shared by the branch resolver
package branch_determination_unit_pkg;
   localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
   localparam logic [2:0] FUNCT3_BNE  = 3'b001;
   localparam logic [2:0] FUNCT3_BLT  = 3'b100;
   localparam logic [2:0] FUNCT3_BGE  = 3'b101;
   localparam logic [2:0] FUNCT3_BLTU = 3'b110;
   localparam logic [2:0] FUNCT3_BGEU = 3'b111;
endpackage

// File: rtl/branch_determination_unit_if.sv
// branch_determination_unit_if: comparator flags and control in, taken decision and debug counters out
interface branch_determination_unit_if #(parameter int CNT_WIDTH = 32);
   logic                 BrEq_i;
   logic                 BrLT_i;
   logic                 BrLTU_i;
   logic                 Branch_i;
   logic [2:0]           funct3_i;
   logic                 BranchTaken_o;
   logic                 BranchTaken_q_o;
   logic                 IllegalFunct3_o;
   logic [CNT_WIDTH-1:0] BranchCnt_o;
   logic [CNT_WIDTH-1:0] TakenCnt_o;
   modport master (
      output BrEq_i, BrLT_i, BrLTU_i, Branch_i, funct3_i,
      input  BranchTaken_o, BranchTaken_q_o, IllegalFunct3_o, BranchCnt_o, TakenCnt_o
   );
   modport slave (
      input  BrEq_i, BrLT_i, BrLTU_i, Branch_i, funct3_i,
      output BranchTaken_o, BranchTaken_q_o, IllegalFunct3_o, BranchCnt_o, TakenCnt_o
   );
endinterface

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational funct3/flag evaluator; odd funct3 selects the inverted condition
module branch_cond_eval
   import branch_determination_unit_pkg::*;
(
   input  logic       i_branch,
   input  logic       i_br_eq,
   input  logic       i_br_lt,
   input  logic       i_br_ltu,
   input  logic [2:0] i_funct3,
   output logic       o_taken,
   output logic       o_illegal
);
   logic w_legal;
   logic w_cond;
   always_comb begin
      w_legal   = i_funct3 inside {FUNCT3_BEQ, FUNCT3_BNE, FUNCT3_BLT, FUNCT3_BGE, FUNCT3_BLTU, FUNCT3_BGEU};
      w_cond    = (i_funct3 inside {FUNCT3_BEQ, FUNCT3_BNE}) ? i_br_eq :
                  (i_funct3 inside {FUNCT3_BLT, FUNCT3_BGE}) ? i_br_lt : i_br_ltu;
      o_taken   = i_branch & w_legal & (w_cond ^ i_funct3[0]);
      o_illegal = i_branch & ~w_legal;
   end
endmodule

// File: rtl/branch_determination_unit.sv
// branch_determination_unit: same-cycle branch decision plus registered copy and branch/taken counters
module branch_determination_unit #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   branch_determination_unit_if.slave  bus
);
   logic                 w_taken;
   logic                 w_illegal;
   logic                 r_taken_q;
   logic [CNT_WIDTH-1:0] r_branch_cnt;
   logic [CNT_WIDTH-1:0] r_taken_cnt;
   branch_cond_eval u_eval (
      .i_branch  (bus.Branch_i),
      .i_br_eq   (bus.BrEq_i),
      .i_br_lt   (bus.BrLT_i),
      .i_br_ltu  (bus.BrLTU_i),
      .i_funct3  (bus.funct3_i),
      .o_taken   (w_taken),
      .o_illegal (w_illegal)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_taken_q    <= 1'b0;
         r_branch_cnt <= '0;
         r_taken_cnt  <= '0;
      end else begin
         r_taken_q    <= w_taken;
         r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(bus.Branch_i);
         r_taken_cnt  <= r_taken_cnt + CNT_WIDTH'(w_taken);
      end
   end
   assign bus.BranchTaken_o   = w_taken;
   assign bus.IllegalFunct3_o = w_illegal;
   assign bus.BranchTaken_q_o = r_taken_q;
   assign bus.BranchCnt_o     = r_branch_cnt;
   assign bus.TakenCnt_o      = r_taken_cnt;
endmodule

// File: tb/tb_branch_determination_unit.sv
// tb_branch_determination_unit: scoreboard bench driving a 32-bit and a 4-bit counter instance in lockstep
module tb_branch_determination_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   branch_determination_unit_if #(.CNT_WIDTH(32)) bus32 ();
   branch_determination_unit_if #(.CNT_WIDTH(4))  bus4 ();
   branch_determination_unit #(.CNT_WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));
   branch_determination_unit #(.CNT_WIDTH(4))  dut4  (.clk_i(clk), .rst_i(rst), .bus(bus4));
   typedef struct {
      logic        taken;
      logic        ill;
      logic        chk_reg;
      logic        tq;
      logic [31:0] bc;
      logic [31:0] tc;
   } exp_t;
   exp_t q[$];
   int n_vec = 0;
   int n_bad = 0;
   logic        m_valid = 1'b0;
   logic        m_tq = 1'b0;
   logic [31:0] m_bc = '0;
   logic [31:0] m_tc = '0;
   // returns {taken, illegal} straight from the RV32I branch table
   function automatic logic [1:0] ref_eval(logic br, logic eq, logic lt, logic ltu, logic [2:0] f3);
      if (!br) return 2'b00;
      case (f3)
         3'b000:  return {eq, 1'b0};
         3'b001:  return {!eq, 1'b0};
         3'b100:  return {lt, 1'b0};
         3'b101:  return {!lt, 1'b0};
         3'b110:  return {ltu, 1'b0};
         3'b111:  return {!ltu, 1'b0};
         default: return 2'b01;
      endcase
   endfunction
   task automatic apply(logic r, logic br, logic eq, logic lt, logic ltu, logic [2:0] f3);
      exp_t e;
      logic [1:0] res;
      @(negedge clk);
      rst = r;
      bus32.Branch_i = br; bus32.BrEq_i = eq; bus32.BrLT_i = lt; bus32.BrLTU_i = ltu; bus32.funct3_i = f3;
      bus4.Branch_i  = br; bus4.BrEq_i  = eq; bus4.BrLT_i  = lt; bus4.BrLTU_i  = ltu; bus4.funct3_i  = f3;
      res = ref_eval(br, eq, lt, ltu, f3);
      e.taken = res[1]; e.ill = res[0];
      e.chk_reg = m_valid; e.tq = m_tq; e.bc = m_bc; e.tc = m_tc;
      q.push_back(e);
      if (r) begin
         m_valid = 1'b1; m_tq = 1'b0; m_bc = '0; m_tc = '0;
      end else begin
         m_tq = res[1];
         m_bc = m_bc + 32'(br);
         m_tc = m_tc + 32'(res[1]);
      end
   endtask
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %0h expected %0h", nm, n_vec, act, exp);
      end
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            n_vec++;
            chk("taken32", 32'(bus32.BranchTaken_o), 32'(e.taken));
            chk("illegal32", 32'(bus32.IllegalFunct3_o), 32'(e.ill));
            chk("taken4", 32'(bus4.BranchTaken_o), 32'(e.taken));
            chk("illegal4", 32'(bus4.IllegalFunct3_o), 32'(e.ill));
            if (e.chk_reg) begin
               chk("taken_q32", 32'(bus32.BranchTaken_q_o), 32'(e.tq));
               chk("bcnt32", bus32.BranchCnt_o, e.bc);
               chk("tcnt32", bus32.TakenCnt_o, e.tc);
               chk("taken_q4", 32'(bus4.BranchTaken_q_o), 32'(e.tq));
               chk("bcnt4", 32'(bus4.BranchCnt_o), e.bc & 32'hf);
               chk("tcnt4", 32'(bus4.TakenCnt_o), e.tc & 32'hf);
            end
         end
      end
   end
   initial begin
      apply(1, 0, 0, 0, 0, 3'b000);
      apply(1, 0, 0, 0, 0, 3'b000);
      apply(0, 0, 1, 1, 1, 3'b000);
      apply(0, 0, 0, 0, 0, 3'b001);
      apply(0, 0, 1, 0, 1, 3'b100);
      apply(0, 1, 1, 0, 0, 3'b000); apply(0, 1, 0, 1, 1, 3'b000);
      apply(0, 1, 0, 1, 1, 3'b001); apply(0, 1, 1, 0, 0, 3'b001);
      apply(0, 1, 0, 1, 0, 3'b100); apply(0, 1, 0, 0, 1, 3'b100);
      apply(0, 1, 0, 0, 1, 3'b101); apply(0, 1, 0, 1, 0, 3'b101);
      apply(0, 1, 0, 0, 1, 3'b110); apply(0, 1, 0, 1, 0, 3'b110);
      apply(0, 1, 0, 1, 0, 3'b111); apply(0, 1, 0, 0, 1, 3'b111);
      apply(0, 1, 1, 1, 1, 3'b111);
      apply(0, 1, 1, 1, 1, 3'b010);
      apply(0, 1, 0, 0, 0, 3'b011);
      apply(1, 0, 0, 0, 0, 3'b000);
      apply(0, 1, 1, 0, 0, 3'b000);
      apply(0, 1, 1, 0, 0, 3'b001);
      apply(0, 1, 0, 1, 0, 3'b100);
      apply(0, 1, 0, 0, 0, 3'b110);
      apply(0, 1, 0, 0, 1, 3'b110);
      apply(0, 0, 0, 0, 0, 3'b000);
      apply(1, 0, 0, 0, 0, 3'b000);
      for (int i = 0; i < 16; i++) apply(0, 1, 1, 0, 0, 3'b000);
      apply(0, 0, 0, 0, 0, 3'b000);
      apply(0, 1, 0, 1, 0, 3'b100);
      apply(1, 1, 0, 1, 0, 3'b100);
      apply(0, 0, 0, 0, 0, 3'b000);
      for (int i = 0; i < 400; i++)
         apply($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
               1'($urandom), 3'($urandom));
      @(negedge clk);
      #4;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/branch_determination_unit.md
Name:
branch_determination_unit

Overview:
- Decode-stage branch resolver for the RV32I core.
- Combines comparator flags (BrEq/BrLT/BrLTU) with the branch control bit and funct3, and produces the branch-taken decision combinationally for same-cycle PC redirect.
- Also provides a registered copy of the decision, an illegal-funct3 flag and branch/taken event counters for pipeline debug and performance monitoring.

Parameters:
- CNT_WIDTH, 32, width of the branch and taken event counters.

Ports:
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- BrEq_i  input  1  rs1 == rs2.
- BrLT_i  input  1  rs1 < rs2, signed.
- BrLTU_i  input  1  rs1 < rs2, unsigned.
- Branch_i  input  1  current instruction is a conditional branch.
- funct3_i  input  3  branch condition selector.
- BranchTaken_o  output  1  combinational taken decision.
- BranchTaken_q_o  output  1  BranchTaken_o registered one cycle.
- IllegalFunct3_o  output  1  combinational; Branch_i=1 with reserved funct3.
- BranchCnt_o  output  CNT_WIDTH  count of cycles with Branch_i=1.
- TakenCnt_o  output  CNT_WIDTH  count of cycles with BranchTaken_o=1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, rst_i).
- BranchTaken_o is purely combinational with zero latency and is not gated by rst_i.
- Branch_i=0 forces BranchTaken_o=0, regardless of flags and funct3.
- With Branch_i=1, BranchTaken_o by funct3:
  - BEQ 3'b000 = BrEq_i
  - BNE 3'b001 = !BrEq_i
  - BLT 3'b100 = BrLT_i
  - BGE 3'b101 = !BrLT_i
  - BLTU 3'b110 = BrLTU_i
  - BGEU 3'b111 = !BrLTU_i
- Reserved funct3 3'b010 and 3'b011: BranchTaken_o=0 and IllegalFunct3_o=1.
- IllegalFunct3_o=0 whenever Branch_i=0.
- Each flag is used independently. Inconsistent combinations (e.g. BrEq=1 together with BrLT=1) are evaluated literally per the table above, with no cross-checking.
- Unused flags for the selected funct3 have no effect.
- X/Z on inputs is not handled specially.
- BranchTaken_q_o: on each rising edge it takes the current BranchTaken_o. Reset value 0.
- BranchCnt_o: increments by 1 on each rising edge where Branch_i=1.
- TakenCnt_o: increments by 1 on each rising edge where BranchTaken_o=1.
- Both counters wrap modulo 2^CNT_WIDTH (all-ones + 1 -> 0). Reset value 0.
- When rst_i=1 at an edge, reset takes priority over increment and capture.
- Reset asserted mid-stream clears all registered state on that edge. The combinational outputs continue to follow the inputs.

Decomposition:
- Shared package defines: FUNCT3_BEQ=3'b000, FUNCT3_BNE=3'b001, FUNCT3_BLT=3'b100, FUNCT3_BGE=3'b101, FUNCT3_BLTU=3'b110, FUNCT3_BGEU=3'b111.
- The block imports these constants; no local re-definition.
- One natural sub-module: branch_cond_eval, the purely combinational funct3/flag evaluator producing the taken and illegal signals.
- The top level adds the registered copy and the counters.

Test Plan:
- Branch_i=0, flags 1/1/1, funct3=BEQ; also 0/0/0 with BNE and 1/0/1 with BLT -> BranchTaken_o=0, IllegalFunct3_o=0, BranchCnt_o unchanged after clock.
- Branch_i=1, each funct3 with taken and not-taken flag sets:
  - BEQ: (1,0,0) -> 1, (0,1,1) -> 0
  - BNE: (0,1,1) -> 1, (1,0,0) -> 0
  - BLT: (0,1,0) -> 1, (0,0,1) -> 0
  - BGE: (0,0,1) -> 1, (0,1,0) -> 0
  - BLTU: (0,0,1) -> 1, (0,1,0) -> 0
  - BGEU: (0,1,0) -> 1, (0,0,1) -> 0
  - Flags are listed as (BrEq, BrLT, BrLTU). Check after #1 settle.
- Branch_i=1, flags 1/1/1, funct3=3'b111 -> BranchTaken_o=0. Funct3 3'b010 and 3'b011 -> BranchTaken_o=0, IllegalFunct3_o=1.
- Clocked sequence after reset: 5 branch cycles, 3 of them taken -> BranchCnt_o=5, TakenCnt_o=3. BranchTaken_q_o equals the previous cycle's BranchTaken_o.
- Counter wrap with CNT_WIDTH=4: 16 taken branches -> both counters return to 0. Assert rst_i mid-sequence -> all registered outputs 0 on the next edge; BranchTaken_o still follows the inputs.
